// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory stage: data memory, branch resolve, MEM/WB register
// Misaligned accesses are squashed and latched into a sticky error flag.
module mem_wb_stage #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Branch_in,
  input  logic              Zero_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       write_data_in,
  input  logic [4:0]        write_reg_in,
  output logic              PCSrc,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [31:0]       read_data_out,
  output logic [31:0]       alu_result_out,
  output logic [4:0]        write_reg_out,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              do_load;
  logic              do_store;

  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [31:0]       read_data_q;
  logic [31:0]       read_data_d;
  logic [31:0]       alu_result_q;
  logic [4:0]        write_reg_q;
  logic              misalign_q;
  logic [CNT_W-1:0]  load_cnt_q;
  logic [CNT_W-1:0]  load_cnt_d;
  logic [CNT_W-1:0]  store_cnt_q;
  logic [CNT_W-1:0]  store_cnt_d;

  assign PCSrc      = Branch_in & Zero_in;
  // Upper address bits are dropped, so addresses alias modulo DEPTH*4.
  assign idx        = alu_result_in[ADDR_W+1:2];
  assign misaligned = (MemRead_in | MemWrite_in) & (alu_result_in[1:0] != 2'b00);
  assign do_load    = MemRead_in & ~misaligned;
  assign do_store   = MemWrite_in & ~misaligned;

  always_comb begin
    read_data_d = 32'h0;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (do_load) begin
      read_data_d = mem_q[idx];
      if (load_cnt_q != {CNT_W{1'b1}}) load_cnt_d = load_cnt_q + CNT_W'(1);
    end
    if (do_store && store_cnt_q != {CNT_W{1'b1}}) store_cnt_d = store_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      write_reg_q  <= 5'd0;
      misalign_q   <= 1'b0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
    end else begin
      // read_data_d sampled the old word, giving read-before-write on RMW.
      if (do_store) mem_q[idx] <= write_data_in;
      reg_write_q  <= RegWrite_in & ~misaligned;
      mem_to_reg_q <= MemtoReg_in;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_in;
      write_reg_q  <= write_reg_in;
      misalign_q   <= misalign_q | misaligned;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  assign RegWrite_out   = reg_write_q;
  assign MemtoReg_out   = mem_to_reg_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign write_reg_out  = write_reg_q;
  assign misalign_err   = misalign_q;
  assign load_count     = load_cnt_q;
  assign store_count    = store_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed vector bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, Zero_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  write_reg_in;

  logic        PCSrc, RegWrite_out, MemtoReg_out, misalign_err;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;
  logic [15:0] load_count, store_count;

  logic        PCSrc4, RegWrite_out4, MemtoReg_out4, misalign_err4;
  logic [31:0] read_data_out4, alu_result_out4;
  logic [4:0]  write_reg_out4;
  logic [3:0]  load_count4, store_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .Zero_in(Zero_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .write_reg_in(write_reg_in),
    .PCSrc(PCSrc), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .misalign_err(misalign_err),
    .load_count(load_count), .store_count(store_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .Zero_in(Zero_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .write_reg_in(write_reg_in),
    .PCSrc(PCSrc4), .RegWrite_out(RegWrite_out4), .MemtoReg_out(MemtoReg_out4),
    .read_data_out(read_data_out4), .alu_result_out(alu_result_out4),
    .write_reg_out(write_reg_out4), .misalign_err(misalign_err4),
    .load_count(load_count4), .store_count(store_count4)
  );

  typedef struct {
    logic        br, zr, rw, mtr, mr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic        e_pcsrc, e_rw, e_mtr, e_mis;
    logic [31:0] e_rd;
    logic [15:0] e_lc, e_sc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, zr, rw, mtr, mr, mw,
                       input logic [31:0] alu, wd, input logic [4:0] wr);
    Branch_in = br; Zero_in = zr; RegWrite_in = rw; MemtoReg_in = mtr;
    MemRead_in = mr; MemWrite_in = mw; alu_result_in = alu;
    write_data_in = wd; write_reg_in = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(logic br, zr, rw, mtr, mr, mw, logic [31:0] alu, wd,
                              logic [4:0] wr, logic e_pcsrc, e_rw, e_mtr, e_mis,
                              logic [31:0] e_rd, logic [15:0] e_lc, e_sc);
    vec_t v;
    v.br = br; v.zr = zr; v.rw = rw; v.mtr = mtr; v.mr = mr; v.mw = mw;
    v.alu = alu; v.wd = wd; v.wr = wr;
    v.e_pcsrc = e_pcsrc; v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_mis = e_mis;
    v.e_rd = e_rd; v.e_lc = e_lc; v.e_sc = e_sc;
    return v;
  endfunction

  initial begin
    //            br zr rw mtr mr mw alu           wd            wr     pc rw mtr mis rd            lc sc
    vecs[0]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0010, 32'hDEADBEEF, 5'd0,  0, 0, 0, 0, 32'h0,        0, 1);
    vecs[1]  = mk(0, 0, 1, 1, 1, 0, 32'h0000_0010, 32'h0,        5'd8,  0, 1, 1, 0, 32'hDEADBEEF, 1, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0104, 32'h12345678, 5'd0,  0, 0, 0, 0, 32'h0,        1, 2);
    vecs[3]  = mk(0, 0, 1, 1, 1, 0, 32'h0000_0004, 32'h0,        5'd3,  0, 1, 1, 0, 32'h12345678, 2, 2);
    vecs[4]  = mk(1, 1, 1, 0, 0, 0, 32'h0000_0055, 32'h0,        5'd5,  1, 1, 0, 0, 32'h0,        2, 2);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 32'h0000_0066, 32'h0,        5'd6,  0, 0, 0, 0, 32'h0,        2, 2);
    vecs[6]  = mk(0, 1, 0, 0, 0, 0, 32'h0000_0077, 32'h0,        5'd7,  0, 0, 0, 0, 32'h0,        2, 2);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0020, 32'h0BADF00D, 5'd0,  0, 0, 0, 0, 32'h0,        2, 3);
    vecs[8]  = mk(0, 0, 1, 1, 1, 0, 32'h0000_0022, 32'h0,        5'd9,  0, 0, 1, 1, 32'h0,        2, 3);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 32'h0000_0023, 32'hFFFFFFFF, 5'd0,  0, 0, 0, 1, 32'h0,        2, 3);
    vecs[10] = mk(0, 0, 1, 1, 1, 0, 32'h0000_0020, 32'h0,        5'd10, 0, 1, 1, 1, 32'h0BADF00D, 3, 3);

    // Reset with random inputs, including possible writes that must be suppressed.
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
            $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom));
      tick();
    end
    chk("rst RegWrite_out", 32'(RegWrite_out), 0);
    chk("rst MemtoReg_out", 32'(MemtoReg_out), 0);
    chk("rst read_data_out", read_data_out, 0);
    chk("rst alu_result_out", alu_result_out, 0);
    chk("rst write_reg_out", 32'(write_reg_out), 0);
    chk("rst misalign_err", 32'(misalign_err), 0);
    chk("rst load_count", 32'(load_count), 0);
    chk("rst store_count", 32'(store_count), 0);
    reset = 1'b0;
    for (int a = 0; a < 64; a++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'(a * 4), 32'h0, 5'd0);
      tick();
      chk($sformatf("rst mem[%0d]", a), read_data_out, 0);
    end
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].br, vecs[i].zr, vecs[i].rw, vecs[i].mtr, vecs[i].mr, vecs[i].mw,
            vecs[i].alu, vecs[i].wd, vecs[i].wr);
      #1;
      chk($sformatf("v%0d PCSrc", i), 32'(PCSrc), 32'(vecs[i].e_pcsrc));
      tick();
      chk($sformatf("v%0d read_data_out", i), read_data_out, vecs[i].e_rd);
      chk($sformatf("v%0d RegWrite_out", i), 32'(RegWrite_out), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d MemtoReg_out", i), 32'(MemtoReg_out), 32'(vecs[i].e_mtr));
      chk($sformatf("v%0d alu_result_out", i), alu_result_out, vecs[i].alu);
      chk($sformatf("v%0d write_reg_out", i), 32'(write_reg_out), 32'(vecs[i].wr));
      chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d load_count", i), 32'(load_count), 32'(vecs[i].e_lc));
      chk($sformatf("v%0d store_count", i), 32'(store_count), 32'(vecs[i].e_sc));
    end

    // Sticky flag holds through idle cycles.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int c = 0; c < 10; c++) tick();
    chk("sticky misalign_err", 32'(misalign_err), 1);
    chk("sticky load_count", 32'(load_count), 3);

    // Saturation on the CNT_W=4 instance.
    do_reset();
    for (int s = 0; s < 17; s++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0030,
            (s == 16) ? 32'hA : 32'(s), 5'd0);
      tick();
    end
    chk("sat store_count", 32'(store_count4), 15);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'hB, 5'd2);
    tick();
    chk("rmw read_data_out", read_data_out4, 32'hA);
    chk("rmw load_count", 32'(load_count4), 1);
    chk("rmw store_count", 32'(store_count4), 15);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 5'd2);
    tick();
    chk("post-rmw read_data_out", read_data_out4, 32'hB);
    chk("post-rmw load_count", 32'(load_count4), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
